hazard_bubble_ctrl: RTL and testbench

//  Parametrised bubble/flush controller for the 5-stage pipelined CPU.

---
 rtl/hazard_bubble_ctrl_if.sv | 27 ++
 rtl/hazard_bubble_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_bubble_ctrl_if.sv
// Interface: hazard_bubble_ctrl_if
// Groups the hazard events, the pipeline-clear pulses and the status signals of
// hazard_bubble_ctrl.
//   master : hazard unit / pipeline side. Drives en, jmp, correct_b and load_use.
//            Observes j_bub, ex_bub, pc_hold, busy and bub_cnt.
//   slave  : the bubble controller.
interface hazard_bubble_ctrl_if;
  logic        en;
  logic        jmp;
  logic        correct_b;
  logic        load_use;
  logic        j_bub;
  logic        ex_bub;
  logic        pc_hold;
  logic        busy;
  logic [31:0] bub_cnt;

  modport master (
    output en, jmp, correct_b, load_use,
    input  j_bub, ex_bub, pc_hold, busy, bub_cnt
  );

  modport slave (
    input  en, jmp, correct_b, load_use,
    output j_bub, ex_bub, pc_hold, busy, bub_cnt
  );
endinterface

// File: rtl/hazard_bubble_ctrl.sv
// Module: hazard_bubble_ctrl
// Bubble/flush controller for the 5-stage pipeline. It converts a jump resolved in ID,
// a branch redirect resolved in EX and a load-use hazard into IF/ID flush (j_bub),
// ID/EX bubble (ex_bub) and PC-hold (pc_hold) pulses. Each pulse lasts a configurable
// number of cycles. Events that arrive from squashed slots are ignored.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low. All outputs read 0 while it is asserted.
//   bus    : hazard_bubble_ctrl_if.slave
//            inputs  : en, jmp, correct_b, load_use
//            outputs : j_bub, ex_bub, pc_hold, busy, bub_cnt
// Optional feature: define BUB_STATS_EN to get a saturating 32-bit counter on bub_cnt.
// The counter counts the cycles on which any bubble output is active. Without the
// macro, bub_cnt is tied to 0.
module hazard_bubble_ctrl #(
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned JMP_BUBBLES = 1,
  parameter int unsigned BR_BUBBLES  = 2,
  parameter int unsigned LOAD_STALL  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_bubble_ctrl_if.slave bus
);

  localparam int unsigned MaxLen = (1 << CNT_W) - 1;

  if ((JMP_BUBBLES < 1) || (JMP_BUBBLES > MaxLen) ||
      (BR_BUBBLES  < 1) || (BR_BUBBLES  > MaxLen) ||
      (LOAD_STALL  < 1) || (LOAD_STALL  > MaxLen)) begin : g_bad_param
`ifdef SYNTHESIS
    $error("hazard_bubble_ctrl: bubble length parameter out of range 1..2^CNT_W-1");
`else
    $fatal(1, "hazard_bubble_ctrl: bubble length parameter out of range 1..2^CNT_W-1");
`endif
  end

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BrInit  = CNT_W'(BR_BUBBLES - 1);
  localparam logic [CNT_W-1:0] JmpInit = CNT_W'(JMP_BUBBLES - 1);
  localparam logic [CNT_W-1:0] LdInit  = CNT_W'(LOAD_STALL - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StStall} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_bub_c, ex_bub_c, pc_hold_c;

  // cnt holds the number of extra cycles still owed after the event cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_bub_c   = 1'b0;
    ex_bub_c  = 1'b0;
    pc_hold_c = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        StIdle, StStall: begin
          // The branch in EX is the oldest instruction, so it also preempts a stall.
          if (bus.correct_b) begin
            j_bub_c  = 1'b1;
            ex_bub_c = 1'b1;
            if (BR_BUBBLES > 1) begin
              state_d = StFlush;
              cnt_d   = BrInit;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else if (state_q == StStall) begin
            pc_hold_c = 1'b1;
            ex_bub_c  = 1'b1;
            if (cnt_q == CntOne) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntOne;
            end
          end else if (bus.jmp) begin
            j_bub_c = 1'b1;
            if (JMP_BUBBLES > 1) begin
              state_d = StFlush;
              cnt_d   = JmpInit;
            end
          end else if (bus.load_use) begin
            pc_hold_c = 1'b1;
            ex_bub_c  = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = StStall;
              cnt_d   = LdInit;
            end
          end
        end
        StFlush: begin
          // Events seen here come from slots being squashed.
          j_bub_c = 1'b1;
          if (cnt_q == CntOne) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The outputs are Mealy in IDLE, so they are gated by reset to read 0 at once.
  assign bus.j_bub   = rst_n & j_bub_c;
  assign bus.ex_bub  = rst_n & ex_bub_c;
  assign bus.pc_hold = rst_n & pc_hold_c;
  assign bus.busy    = (state_q != StIdle);

`ifdef BUB_STATS_EN
  logic [31:0] stats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else if ((j_bub_c | ex_bub_c | pc_hold_c) && (stats_q != 32'hFFFF_FFFF)) begin
      stats_q <= stats_q + 32'd1;
    end
  end

  assign bus.bub_cnt = stats_q;
`else
  assign bus.bub_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Testbench for hazard_bubble_ctrl. Three parameterisations receive the same stimulus.
// Each cycle, a queue-based reference model pushes the expected outputs of each DUT
// into a scoreboard queue. A negedge monitor pops each entry and compares it with
// the DUT outputs.
module tb_hazard_bubble_ctrl;

  localparam int NDut = 3;
  localparam int unsigned JB[NDut] = '{1, 3, 3};
  localparam int unsigned BB[NDut] = '{2, 7, 1};
  localparam int unsigned LS[NDut] = '{1, 3, 2};

  typedef struct packed {
    logic        j;
    logic        ex;
    logic        ph;
    logic        busy;
    logic [31:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en, jmp, cb, lu;

  always #5 clk = ~clk;

  hazard_bubble_ctrl_if hif0 ();
  hazard_bubble_ctrl_if hif1 ();
  hazard_bubble_ctrl_if hif2 ();

  assign hif0.en = en;  assign hif0.jmp = jmp;  assign hif0.correct_b = cb;
  assign hif0.load_use = lu;
  assign hif1.en = en;  assign hif1.jmp = jmp;  assign hif1.correct_b = cb;
  assign hif1.load_use = lu;
  assign hif2.en = en;  assign hif2.jmp = jmp;  assign hif2.correct_b = cb;
  assign hif2.load_use = lu;

  hazard_bubble_ctrl #(.CNT_W(3), .JMP_BUBBLES(1), .BR_BUBBLES(2), .LOAD_STALL(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(hif0)
  );
  hazard_bubble_ctrl #(.CNT_W(3), .JMP_BUBBLES(3), .BR_BUBBLES(7), .LOAD_STALL(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(hif1)
  );
  hazard_bubble_ctrl #(.CNT_W(2), .JMP_BUBBLES(3), .BR_BUBBLES(1), .LOAD_STALL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(hif2)
  );

  // Reference model: a list of owed bubble slots per DUT (0 = flush slot, 1 = stall slot).
  bit          pend[NDut][$];
  int unsigned stats[NDut];
  obs_t        exp_q[NDut][$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cycle  = 0;

  task automatic model_step(input int c, input bit r, e, j, b, l);
    obs_t o;
    bit   tmp;
    o = '0;
    if (!r) begin
      pend[c].delete();
      stats[c] = 0;
    end else begin
      o.busy = (pend[c].size() != 0);
`ifdef BUB_STATS_EN
      o.cnt = stats[c];
`endif
      if (e) begin
        if (pend[c].size() != 0 && pend[c][0] == 1'b0) begin
          o.j = 1'b1;
          tmp = pend[c].pop_front();
        end else if (b) begin
          o.j  = 1'b1;
          o.ex = 1'b1;
          pend[c].delete();
          for (int k = 1; k < int'(BB[c]); k++) pend[c].push_back(1'b0);
        end else if (pend[c].size() != 0) begin
          o.ph = 1'b1;
          o.ex = 1'b1;
          tmp  = pend[c].pop_front();
        end else if (j) begin
          o.j = 1'b1;
          for (int k = 1; k < int'(JB[c]); k++) pend[c].push_back(1'b0);
        end else if (l) begin
          o.ph = 1'b1;
          o.ex = 1'b1;
          for (int k = 1; k < int'(LS[c]); k++) pend[c].push_back(1'b1);
        end
        if (o.j || o.ex || o.ph) stats[c] = stats[c] + 1;
      end
    end
    exp_q[c].push_back(o);
  endtask

  task automatic drive(input bit r, e, j, b, l);
    @(posedge clk);
    #1;
    rst_n = r; en = e; jmp = j; cb = b; lu = l;
    cycle++;
    for (int c = 0; c < NDut; c++) model_step(c, r, e, j, b, l);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic obs_t actual(input int c);
    obs_t a;
    case (c)
      0:       a = {hif0.j_bub, hif0.ex_bub, hif0.pc_hold, hif0.busy, hif0.bub_cnt};
      1:       a = {hif1.j_bub, hif1.ex_bub, hif1.pc_hold, hif1.busy, hif1.bub_cnt};
      default: a = {hif2.j_bub, hif2.ex_bub, hif2.pc_hold, hif2.busy, hif2.bub_cnt};
    endcase
    return a;
  endfunction

  task automatic check(input int c);
    obs_t e, a;
    if (exp_q[c].size() != 0) begin
      e = exp_q[c].pop_front();
      a = actual(c);
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs dut%0d cycle %0d: got j=%b ex=%b ph=%b busy=%b cnt=%0d, want j=%b ex=%b ph=%b busy=%b cnt=%0d",
                 c, cycle, a.j, a.ex, a.ph, a.busy, a.cnt, e.j, e.ex, e.ph, e.busy, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NDut; c++) check(c);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; jmp = 1'b0; cb = 1'b0; lu = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);      // outputs stay 0 while in reset
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);      // single jump
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);      // branch then jump from squashed slot
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(8);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);      // all events at once: branch wins
    idle(8);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);      // plain load-use
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);      // load-use preempted by branch
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(8);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);      // jump, then frozen pipeline
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);      // reset in the middle of a flush
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(9) != 0), ($urandom_range(4) == 0),
            ($urandom_range(5) == 0), ($urandom_range(3) == 0));
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
